// File: rtl/feinv_if.sv
// Bus between the field inverter (master) and an external femul multiplier (slave).
interface feinv_if #(
    parameter int unsigned W = 255
);
    logic         mul_start;
    logic [W-1:0] mul_a;
    logic [W-1:0] mul_b;
    logic         mul_done;
    logic [W-1:0] mul_out;

    modport master (
        output mul_start,
        output mul_a,
        output mul_b,
        input  mul_done,
        input  mul_out
    );

    modport slave (
        input  mul_start,
        input  mul_a,
        input  mul_b,
        output mul_done,
        output mul_out
    );
endinterface

// File: rtl/feinv.sv
// feinv: field inverter for GF(2^255-19), out = a_in^(p-2) by left-to-right
// square-and-multiply, driving an external femul over the feinv_if bus.
// Optional macro FEINV_CHECK_EN adds a trailing acc*base multiply whose result
// (1 or p+1) sets ok; without it ok is constant 1 out of reset.
module feinv #(
    parameter int unsigned EXP_BITS = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [EXP_BITS-1:0] a_in,
    output logic                done,
    output logic [EXP_BITS-1:0] out,
    output logic                ok,
    feinv_if.master             mul
);
    localparam int unsigned W     = EXP_BITS;
    localparam int unsigned IDX_W = 8;
    // Exponent p-2 = 2^255-21; bit W-1 is implicit in acc = base at start.
    localparam logic [W-1:0] EXP  = {{(W - 5){1'b1}}, 5'b01011};
`ifdef FEINV_CHECK_EN
    localparam logic [W-1:0] P_PLUS_1 = {{(W - 5){1'b1}}, 5'b01110};
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_SQ_ISSUE,
        S_MUL_ISSUE,
        S_WAIT,
        S_FINISH,
        S_CHK_ISSUE,
        S_CHK_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       acc_q, acc_d;
    logic [W-1:0]       base_q, base_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               op_q, op_d;
    logic               mul_start_q, mul_start_d;
    logic [W-1:0]       mul_a_q, mul_a_d;
    logic [W-1:0]       mul_b_q, mul_b_d;
`ifdef FEINV_CHECK_EN
    logic               ok_d;
`endif

    assign mul.mul_start = mul_start_q;
    assign mul.mul_a     = mul_a_q;
    assign mul.mul_b     = mul_b_q;

    // Next-state logic; multiplier operands are prepared for the state being entered
    // so mul_start is high exactly during the issue cycle.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        base_d      = base_q;
        idx_d       = idx_q;
        op_d        = op_q;
        mul_start_d = 1'b0;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
`ifdef FEINV_CHECK_EN
        ok_d        = ok;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = a_in;
                    acc_d   = a_in;
                    idx_d   = IDX_W'(EXP_BITS - 2);
                    state_d = S_SQ_ISSUE;
                end
            end
            S_SQ_ISSUE: begin
                op_d    = 1'b0;
                state_d = S_WAIT;
            end
            S_MUL_ISSUE: begin
                op_d    = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mul.mul_done) begin
                    acc_d = mul.mul_out;
                    if (!op_q && EXP[idx_q]) begin
                        state_d = S_MUL_ISSUE;
                    end else if (idx_q == '0) begin
`ifdef FEINV_CHECK_EN
                        state_d = S_CHK_ISSUE;
`else
                        state_d = S_FINISH;
`endif
                    end else begin
                        idx_d   = IDX_W'(idx_q - IDX_W'(1));
                        state_d = S_SQ_ISSUE;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
`ifdef FEINV_CHECK_EN
            S_CHK_ISSUE: begin
                state_d = S_CHK_WAIT;
            end
            S_CHK_WAIT: begin
                if (mul.mul_done) begin
                    ok_d    = (mul.mul_out == W'(1)) || (mul.mul_out == P_PLUS_1);
                    state_d = S_FINISH;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_SQ_ISSUE || state_d == S_MUL_ISSUE || state_d == S_CHK_ISSUE) begin
            mul_start_d = 1'b1;
            mul_a_d     = acc_d;
            mul_b_d     = (state_d == S_SQ_ISSUE) ? acc_d : base_d;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            base_q      <= '0;
            idx_q       <= '0;
            op_q        <= 1'b0;
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            done        <= 1'b0;
            out         <= '0;
            ok          <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            base_q      <= base_d;
            idx_q       <= idx_d;
            op_q        <= op_d;
            mul_start_q <= mul_start_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            done        <= (state_q == S_FINISH);
            if (state_q == S_FINISH) begin
                out <= acc_q;
            end
`ifdef FEINV_CHECK_EN
            ok          <= ok_d;
`else
            ok          <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_feinv.sv
// Bench for feinv: behavioural femul with fixed latency L, scoreboard of expected results.
module tb_feinv;
    localparam int unsigned W  = 255;
    localparam int unsigned W2 = 2 * W;
    localparam int unsigned L  = 3;
    localparam logic [W-1:0] P = {{250{1'b1}}, 5'b01101};
`ifdef FEINV_CHECK_EN
    localparam int unsigned N_OPS = 507;
`else
    localparam int unsigned N_OPS = 506;
`endif
    localparam int unsigned LAT    = N_OPS * (L + 1) + 2;
    localparam int unsigned BUDGET = LAT + 200;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] exp;
        bit           by_product;
        bit           ok_exp;
    } sb_t;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a_in  = '0;
    logic         done;
    logic [W-1:0] out;
    logic         ok;

    feinv_if #(.W(W)) mul ();

    feinv dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .a_in  (a_in),
        .done  (done),
        .out   (out),
        .ok    (ok),
        .mul   (mul)
    );

    always #5 clock = ~clock;

    function automatic logic [W-1:0] mulmod(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W2-1:0] pr;
        pr = W2'(x) * W2'(y);
        return W'(pr % W2'(P));
    endfunction

    // femul model: no reset, one op in flight, done L cycles after start.
    logic [L:1]   pipe = '0;
    logic [W-1:0] res  = '0;
    always @(posedge clock) begin
        pipe <= {pipe[L-1:1], mul.mul_start};
        if (mul.mul_start) res <= mulmod(mul.mul_a, mul.mul_b);
    end
    assign mul.mul_done = pipe[L];
    assign mul.mul_out  = res;

    int unsigned cyc    = 0;
    int unsigned nstart = 0;
    int unsigned ndone  = 0;
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (mul.mul_start) nstart <= nstart + 1;
        if (done) ndone <= ndone + 1;
    end

    sb_t sb[$];
    int  errors = 0;
    int  checks = 0;

    function automatic bit ok_for(input logic [W-1:0] a);
`ifdef FEINV_CHECK_EN
        return (a % P) != '0;
`else
        return a == a;
`endif
    endfunction

    task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] e, input bit by_product);
        sb_t s;
        s.a = a; s.exp = e; s.by_product = by_product; s.ok_exp = ok_for(a);
        sb.push_back(s);
    endtask

    task automatic pulse_start(input logic [W-1:0] a, output int unsigned t0, output int unsigned s0);
        @(negedge clock);
        a_in  = a;
        start = 1'b1;
        t0    = cyc;
        s0    = nstart;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int unsigned budget, output bit seen);
        int unsigned n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        seen = (done === 1'b1);
    endtask

    task automatic recover();
        sb.delete();
        reset = 1'b1;
        repeat (L + 2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (out !== '0)         begin errors++; $display("FAIL reset_out: got %h want 0", out); end
        checks++; if (ok !== 1'b0)        begin errors++; $display("FAIL reset_ok: got %b want 0", ok); end
        checks++; if (mul.mul_start !== 1'b0) begin errors++; $display("FAIL reset_mul_start: got %b want 0", mul.mul_start); end
        checks++; if (mul.mul_a !== '0)   begin errors++; $display("FAIL reset_mul_a: got %h want 0", mul.mul_a); end
        checks++; if (mul.mul_b !== '0)   begin errors++; $display("FAIL reset_mul_b: got %h want 0", mul.mul_b); end
        reset = 1'b0;
        @(negedge clock);
`ifdef FEINV_CHECK_EN
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL post_reset_ok: got %b want 0", ok); end
`else
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL post_reset_ok: got %b want 1", ok); end
`endif
    endtask

    task automatic test_inversion(input string name, input logic [W-1:0] a,
                                  input logic [W-1:0] e_val, input bit by_product);
        sb_t          e;
        int unsigned  t0, s0;
        bit           seen;
        logic [W-1:0] q, held;
        push_exp(a, e_val, by_product);
        pulse_start(a, t0, s0);
        wait_done(BUDGET, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, BUDGET);
            recover();
        end else begin
            e = sb.pop_front();
            q = e.by_product ? mulmod(out, e.a) : W'(out % P);
            checks++; if (q !== e.exp) begin errors++; $display("FAIL %s_value: got %h want %h", name, q, e.exp); end
            checks++; if (ok !== e.ok_exp) begin errors++; $display("FAIL %s_ok: got %b want %b", name, ok, e.ok_exp); end
            checks++; if (cyc - t0 != LAT) begin errors++; $display("FAIL %s_latency: got %0d want %0d", name, cyc - t0, LAT); end
            checks++; if (nstart - s0 != N_OPS) begin errors++; $display("FAIL %s_pulses: got %0d want %0d", name, nstart - s0, N_OPS); end
            held = out;
            @(negedge clock);
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_width: got %b want 0", name, done); end
            checks++; if (out !== held) begin errors++; $display("FAIL %s_out_hold: got %h want %h", name, out, held); end
        end
    endtask

    task automatic test_ignore_start();
        sb_t          e;
        int unsigned  t0, s0, d0, n;
        bit           seen;
        logic [W-1:0] q;
        push_exp(W'(5), W'(1), 1'b1);
        pulse_start(W'(5), t0, s0);
        d0 = ndone;
        n  = 0;
        while (nstart - s0 < 100 && n < BUDGET) begin @(negedge clock); n++; end
        a_in  = W'(7);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(BUDGET, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL ignore_timeout: no done within %0d cycles", BUDGET);
            recover();
        end else begin
            e = sb.pop_front();
            q = mulmod(out, e.a);
            checks++; if (q !== e.exp) begin errors++; $display("FAIL ignore_value: got %h want %h", q, e.exp); end
            checks++; if (cyc - t0 != LAT) begin errors++; $display("FAIL ignore_latency: got %0d want %0d", cyc - t0, LAT); end
            checks++; if (nstart - s0 != N_OPS) begin errors++; $display("FAIL ignore_pulses: got %0d want %0d", nstart - s0, N_OPS); end
            repeat (L + 10) @(negedge clock);
            checks++; if (ndone - d0 != 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", ndone - d0); end
        end
    endtask

    task automatic test_reset_mid();
        sb_t          e;
        int unsigned  t0, s0, d0, n;
        bit           seen;
        logic [W-1:0] q;
        push_exp(W'(11), W'(1), 1'b1);
        pulse_start(W'(11), t0, s0);
        n = 0;
        while (nstart - s0 < 300 && n < BUDGET) begin @(negedge clock); n++; end
        d0    = ndone;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        void'(sb.pop_front());
        checks++; if (out !== '0)    begin errors++; $display("FAIL midreset_out: got %h want 0", out); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b want 0", done); end
        repeat (L + 1) @(negedge clock);
        push_exp(W'(3), W'(1), 1'b1);
        pulse_start(W'(3), t0, s0);
        wait_done(BUDGET, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL midreset_timeout: no done within %0d cycles", BUDGET);
            recover();
        end else begin
            e = sb.pop_front();
            q = mulmod(out, e.a);
            checks++; if (q !== e.exp) begin errors++; $display("FAIL midreset_value: got %h want %h", q, e.exp); end
            checks++; if (ndone - d0 != 0) begin errors++; $display("FAIL midreset_spurious_done: got %0d want 0", ndone - d0); end
            checks++; if (cyc - t0 != LAT) begin errors++; $display("FAIL midreset_latency: got %0d want %0d", cyc - t0, LAT); end
            @(negedge clock);
        end
    endtask

    task automatic test_back_to_back();
        sb_t          e;
        int unsigned  t0, s0;
        bit           seen;
        logic [W-1:0] q;
        push_exp(W'(4), W'(1), 1'b1);
        pulse_start(W'(4), t0, s0);
        wait_done(BUDGET, seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL b2b_first_timeout: no done within %0d cycles", BUDGET);
            recover();
        end else begin
            e = sb.pop_front();
            q = mulmod(out, e.a);
            checks++; if (q !== e.exp) begin errors++; $display("FAIL b2b_first_value: got %h want %h", q, e.exp); end
            // done cycle is already IDLE, so a start here is accepted
            push_exp(W'(6), W'(1), 1'b1);
            a_in  = W'(6);
            start = 1'b1;
            t0    = cyc;
            s0    = nstart;
            @(negedge clock);
            start = 1'b0;
            wait_done(BUDGET, seen);
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL b2b_second_timeout: no done within %0d cycles", BUDGET);
                recover();
            end else begin
                e = sb.pop_front();
                q = mulmod(out, e.a);
                checks++; if (q !== e.exp) begin errors++; $display("FAIL b2b_second_value: got %h want %h", q, e.exp); end
                checks++; if (cyc - t0 != LAT) begin errors++; $display("FAIL b2b_second_latency: got %0d want %0d", cyc - t0, LAT); end
                checks++; if (nstart - s0 != N_OPS) begin errors++; $display("FAIL b2b_second_pulses: got %0d want %0d", nstart - s0, N_OPS); end
                @(negedge clock);
            end
        end
    endtask

    initial begin
        logic [W-1:0] half;
        logic [W-1:0] pm1;
        half = (W'(1) << 254) - W'(9);
        pm1  = P - W'(1);
        test_reset();
        test_inversion("one",  W'(1), W'(1), 1'b0);
        test_inversion("two",  W'(2), half,  1'b0);
        test_inversion("pm1",  pm1,   pm1,   1'b0);
        test_inversion("nine", W'(9), W'(1), 1'b1);
        test_inversion("zero", W'(0), W'(0), 1'b0);
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
